joypad_port_ctrl: RTL and testbench
===================================

JOYPAD_PORT_CTRL -- requirements
Module: joypad_port_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of controller ports; legal values 1..2.
REQ-002 SHALL have parameter SHIFT_LEN, default 8: buttons per port; legal values 8..24.
REQ-003 SHALL have parameter BASE_ADDR, default 16'h4016: port 0 address; port p is at BASE_ADDR+p.
REQ-004 SHALL have parameter OPEN_BUS, default 7'h20: value driven on cpu_rdata[7:1].
REQ-005 SHALL have parameter TURBO_DIV, default 16'd2000: clock cycles per turbo phase; minimum 1.
REQ-006 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port cpu_addr  input  16  CPU bus address.
REQ-009 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-010 SHALL have port cpu_write_en  input  1  single-cycle write strobe.
REQ-011 SHALL have port cpu_read_en  input  1  single-cycle read strobe.
REQ-012 SHALL have port cpu_rdata  output  8  registered read data.
REQ-013 SHALL have port cpu_rdata_valid  output  1  one-cycle pulse; cpu_rdata is valid on that cycle.
REQ-014 SHALL have port pad_buttons  input  NUM_PORTS*SHIFT_LEN  live button states (1 = pressed); port p occupies bits [p*SHIFT_LEN +: SHIFT_LEN]; bit 0 is A.
REQ-015 SHALL have port pad_turbo  input  2*NUM_PORTS  turbo-A/turbo-B requests; port p occupies bits [2p+1:2p], with bit 2p = A.
REQ-016 SHALL have port strobe_out  output  1  current strobe latch state.

Function
REQ-017 A write to BASE_ADDR SHALL set strobe to cpu_wdata[0]; a write to BASE_ADDR+1 SHALL be ignored.
REQ-018 While strobe=1, each channel SHALL reload its shift register from pad_buttons every cycle and set its bit count to 0.
REQ-019 On the cycle strobe goes 1->0, each channel SHALL hold the value loaded on the last cycle strobe was 1.
REQ-020 A read of BASE_ADDR+p with strobe=0 SHALL return the channel's bit 0 on cpu_rdata[0], then shift right by one and increment the count.
REQ-021 Once the count reaches SHIFT_LEN, reads SHALL return 1 and the count SHALL saturate (no wrap).
REQ-022 A read with strobe=1 SHALL return the live A button and SHALL NOT shift.
REQ-023 cpu_rdata SHALL equal {OPEN_BUS, bit} with cpu_rdata_valid=1, exactly one cycle after the read cycle (latency 1).
REQ-024 If a read and a strobe write occur in the same cycle, the read SHALL use the pre-write state and the write SHALL take effect on the next cycle.
REQ-025 A read to an address above BASE_ADDR+NUM_PORTS-1 SHALL produce no cpu_rdata_valid pulse.
REQ-026 Channels SHALL be independent; reading port 0 SHALL NOT shift port 1.

Reset
REQ-027 While rst=1: strobe=0, all shift registers=0, all counts=SHIFT_LEN (exhausted), cpu_rdata=8'h00, cpu_rdata_valid=0, turbo divider=0, turbo phase=0.
REQ-028 Asserting rst mid-sequence SHALL abandon the sequence; after reset, reads SHALL return 1 until the next strobe.

Configuration
REQ-029 When JOYPAD_TURBO_EN is defined: a free-running divider SHALL toggle a turbo phase every TURBO_DIV cycles, and a load SHALL replace A (or B) with the phase for each port whose matching pad_turbo bit is 1.
REQ-030 When JOYPAD_TURBO_EN is undefined: pad_turbo SHALL remain present but be ignored, and no divider SHALL be synthesised.

Structure
REQ-031 Package joypad_pkg SHALL hold the default parameters, the OPEN_BUS default, and the address offset constants.
REQ-032 Sub-module joypad_shift_chan SHALL implement one port's shift register, count and saturation, and SHALL be instantiated NUM_PORTS times.

Verification
REQ-033 Bench SHALL check: pad0=8'b1000_0101, write 1 then 0 to 4016, eight reads of 4016 -> bit0 sequence 1,0,1,0,0,0,0,1; cpu_rdata=8'h41/8'h40.
REQ-034 Bench SHALL check: after those 8 reads, reads 9 and 10 -> 8'h41 both times.
REQ-035 Bench SHALL check: strobe held 1, pad0 A toggling, three reads -> each returns the live A with no shift; releasing strobe then reading -> A captured on the last strobe cycle.
REQ-036 Bench SHALL check: pad1=8'h02, latch, read 4017 twice -> 0 then 1; port 0 count unchanged.
REQ-037 Bench SHALL check: rst pulsed after 3 reads -> the next read returns 8'h41; reading 4018 -> no valid pulse.
REQ-038 Bench SHALL check with JOYPAD_TURBO_EN, TURBO_DIV=4: turbo-A held, latch every cycle -> loaded A alternates every 4 cycles.

Source files
------------

// File: rtl/joypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : joypad_pkg
// Description : Shared defaults and address-offset constants for the joypad
//               serial port controller and its per-port shift channel.
// Revision    : 1.0 - initial release
// ============================================================================
package joypad_pkg;

    // Default configuration of joypad_port_ctrl
    localparam int          c_def_num_ports = 2;
    localparam int          c_def_shift_len = 8;
    localparam logic [15:0] c_def_base_addr = 16'h4016;
    localparam logic [6:0]  c_def_open_bus  = 7'h20;
    localparam logic [15:0] c_def_turbo_div = 16'd2000;

    // Register offsets relative to the base address. The strobe latch shares
    // its address with port 0; port p reads at offset c_ofs_port0 + p.
    localparam logic [15:0] c_ofs_strobe = 16'd0;
    localparam logic [15:0] c_ofs_port0  = 16'd0;
    localparam logic [15:0] c_ofs_port1  = 16'd1;

endpackage : joypad_pkg
`default_nettype wire

// File: rtl/joypad_shift_chan.sv
`default_nettype none
// ============================================================================
// Module      : joypad_shift_chan
// Description : One controller port: parallel-load shift register with a
//               saturating bit counter. Once all SHIFT_LEN bits have been
//               shifted out the output reads as 1.
// Ports       : clk, rst (async, active-high)
//               load_i      - reload from load_data_i and clear the count
//               load_data_i - button snapshot (bit 0 shifted out first)
//               shift_i     - advance one bit (ignored while load_i is high)
//               bit_o       - bit currently presented to the CPU
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_shift_chan
    import joypad_pkg::*;
#(
    parameter int SHIFT_LEN = c_def_shift_len
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [SHIFT_LEN-1:0] load_data_i,
    input  logic                 shift_i,
    output logic                 bit_o
);

    localparam int             CW         = $clog2(SHIFT_LEN + 1);
    localparam logic [CW-1:0]  c_cnt_full = CW'(SHIFT_LEN);

    logic [SHIFT_LEN-1:0] sr_q, sr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = load_data_i;
            cnt_d = '0;
        end else if (shift_i && (cnt_q != c_cnt_full)) begin
            // Count saturates at SHIFT_LEN, so reads past the end never wrap
            sr_d  = {1'b1, sr_q[SHIFT_LEN-1:1]};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= c_cnt_full;   // exhausted: reads return 1 until a strobe
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o = (cnt_q == c_cnt_full) ? 1'b1 : sr_q[0];

endmodule : joypad_shift_chan
`default_nettype wire

// File: rtl/joypad_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : joypad_port_ctrl
// Description : CPU-mapped serial controller ports. A write to BASE_ADDR sets
//               the strobe latch; while strobe is high every channel reloads
//               from pad_buttons. Reads of BASE_ADDR+p shift port p and return
//               {OPEN_BUS, bit} one cycle later with cpu_rdata_valid.
// Ports       : clk, rst (async, active-high)
//               cpu_addr/cpu_wdata/cpu_write_en/cpu_read_en - CPU bus
//               cpu_rdata/cpu_rdata_valid - registered read response
//               pad_buttons - NUM_PORTS*SHIFT_LEN live buttons, bit 0 = A
//               pad_turbo   - per port {turbo-B, turbo-A} requests
//               strobe_out  - current strobe latch state
// Options     : JOYPAD_TURBO_EN - adds a free-running turbo divider; loads
//               substitute the turbo phase for A/B where requested. Without
//               it pad_turbo is accepted and ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_port_ctrl
    import joypad_pkg::*;
#(
    parameter int          NUM_PORTS = c_def_num_ports,
    parameter int          SHIFT_LEN = c_def_shift_len,
    parameter logic [15:0] BASE_ADDR = c_def_base_addr,
    parameter logic [6:0]  OPEN_BUS  = c_def_open_bus,
    parameter logic [15:0] TURBO_DIV = c_def_turbo_div
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [15:0]                    cpu_addr,
    input  logic [7:0]                     cpu_wdata,
    input  logic                           cpu_write_en,
    input  logic                           cpu_read_en,
    output logic [7:0]                     cpu_rdata,
    output logic                           cpu_rdata_valid,
    input  logic [NUM_PORTS*SHIFT_LEN-1:0] pad_buttons,
    input  logic [2*NUM_PORTS-1:0]         pad_turbo,
    output logic                           strobe_out
);

    logic                 strobe_q;
    logic [7:0]           rdata_q;
    logic                 valid_q;

    logic [15:0]          w_ofs;
    logic                 w_rd_hit;
    logic                 w_wr_strobe;
    logic                 w_bit;
    logic [NUM_PORTS-1:0] w_sel;
    logic [NUM_PORTS-1:0] w_live_a;
    logic [NUM_PORTS-1:0] w_chan_bit;
    logic                 w_phase;

    assign w_ofs       = cpu_addr - BASE_ADDR;
    assign w_rd_hit    = cpu_read_en && (w_ofs < 16'(NUM_PORTS));
    assign w_wr_strobe = cpu_write_en && (cpu_addr == BASE_ADDR + c_ofs_strobe);

`ifdef JOYPAD_TURBO_EN
    // Turbo phase flips every TURBO_DIV cycles, independent of CPU activity
    logic [15:0] div_q;
    logic        phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else if (div_q == TURBO_DIV - 16'd1) begin
            div_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            div_q   <= div_q + 16'd1;
        end
    end

    assign w_phase = phase_q;
`else
    assign w_phase = 1'b0;
`endif

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [SHIFT_LEN-1:0] w_load;

            always_comb begin
                w_load = pad_buttons[p*SHIFT_LEN +: SHIFT_LEN];
`ifdef JOYPAD_TURBO_EN
                if (pad_turbo[2*p])   w_load[0] = w_phase;
                if (pad_turbo[2*p+1]) w_load[1] = w_phase;
`endif
            end

            assign w_sel[p]    = (w_ofs == c_ofs_port0 + 16'(p));
            assign w_live_a[p] = w_load[0];

            joypad_shift_chan #(
                .SHIFT_LEN (SHIFT_LEN)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .load_i      (strobe_q),
                .load_data_i (w_load),
                .shift_i     (w_rd_hit && w_sel[p] && !strobe_q),
                .bit_o       (w_chan_bit[p])
            );
        end
    endgenerate

    // While strobe is high the channel is reloading every cycle, so the CPU
    // sees the A button being loaded rather than the (frozen) shift output.
    always_comb begin
        w_bit = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sel[p]) w_bit = strobe_q ? w_live_a[p] : w_chan_bit[p];
        end
    end

    // Strobe is registered, so a read in the same cycle as a strobe write
    // still observes the pre-write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
            rdata_q  <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            if (w_wr_strobe) strobe_q <= cpu_wdata[0];
            valid_q <= w_rd_hit;
            if (w_rd_hit) rdata_q <= {OPEN_BUS, w_bit};
        end
    end

    assign cpu_rdata       = rdata_q;
    assign cpu_rdata_valid = valid_q;
    assign strobe_out      = strobe_q;

    // Inputs that carry no function in every configuration
    logic w_unused_inputs;
    assign w_unused_inputs = &{1'b0, cpu_wdata[7:1], pad_turbo, w_phase};

endmodule : joypad_port_ctrl
`default_nettype wire

// File: tb/tb_joypad_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_joypad_port_ctrl
// Description : Self-checking bench for joypad_port_ctrl. A bench-side model
//               keeps one bit queue per port (filled on strobe release,
//               drained by reads, empty => 1) and predicts every response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joypad_port_ctrl;

`ifdef JOYPAD_TURBO_EN
    localparam logic [15:0] c_tb_turbo_div = 16'd4;
`else
    localparam logic [15:0] c_tb_turbo_div = 16'd2000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_write_en = 1'b0;
    logic        cpu_read_en = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_valid;
    logic [15:0] pad_buttons = 16'h0000;
    logic [3:0]  pad_turbo = 4'h0;
    logic        strobe_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic strobe_m = 1'b0;
    logic q0[$];
    logic q1[$];

    always #5 clk = ~clk;

    joypad_port_ctrl #(
        .TURBO_DIV (c_tb_turbo_div)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_write_en    (cpu_write_en),
        .cpu_read_en     (cpu_read_en),
        .cpu_rdata       (cpu_rdata),
        .cpu_rdata_valid (cpu_rdata_valid),
        .pad_buttons     (pad_buttons),
        .pad_turbo       (pad_turbo),
        .strobe_out      (strobe_out)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus cycle; outputs are sampled 1 time unit after the active edge
    task automatic step(input logic [15:0] addr, input logic [7:0] wd,
                        input logic we, input logic re,
                        output logic [7:0] rd, output logic v);
        @(negedge clk);
        cpu_addr = addr; cpu_wdata = wd; cpu_write_en = we; cpu_read_en = re;
        @(posedge clk);
        #1;
        cpu_write_en = 1'b0; cpu_read_en = 1'b0;
        rd = cpu_rdata; v = cpu_rdata_valid;
    endtask

    function automatic logic model_pop(input int p);
        logic b;
        b = 1'b1;
        if (p == 0) begin
            if (q0.size() > 0) b = q0.pop_front();
        end else begin
            if (q1.size() > 0) b = q1.pop_front();
        end
        return b;
    endfunction

    // Predict the response using pre-cycle state, then apply the write
    task automatic model(input logic [15:0] addr, input logic [7:0] wd,
                         input logic we, input logic re,
                         output logic exp_v, output logic [7:0] exp_rd);
        int  p;
        logic b;
        exp_v = 1'b0; exp_rd = 8'h00;
        if (re && (addr == 16'h4016 || addr == 16'h4017)) begin
            p = (addr == 16'h4017) ? 1 : 0;
            b = strobe_m ? pad_buttons[p*8] : model_pop(p);
            exp_v = 1'b1;
            exp_rd = {7'h20, b};
        end
        if (we && addr == 16'h4016) begin
            if (strobe_m && !wd[0]) begin
                q0.delete(); q1.delete();
                for (int i = 0; i < 8; i++) begin
                    q0.push_back(pad_buttons[i]);
                    q1.push_back(pad_buttons[8+i]);
                end
            end
            strobe_m = wd[0];
        end
    endtask

    task automatic xfer(input string tag, input logic [15:0] addr, input logic [7:0] wd,
                        input logic we, input logic re, output logic [7:0] rd);
        logic       ev, v;
        logic [7:0] er;
        model(addr, wd, we, re, ev, er);
        step(addr, wd, we, re, rd, v);
        check({tag, ".valid"}, {7'h0, v}, {7'h0, ev});
        if (ev) check({tag, ".rdata"}, rd, er);
        check({tag, ".strobe"}, {7'h0, strobe_out}, {7'h0, strobe_m});
    endtask

    task automatic latch(input string tag);
        logic [7:0] rd;
        xfer({tag, ".s1"}, 16'h4016, 8'h01, 1'b1, 1'b0, rd);
        xfer({tag, ".s0"}, 16'h4016, 8'h00, 1'b1, 1'b0, rd);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst.rdata", cpu_rdata, 8'h00);
        check("rst.valid", {7'h0, cpu_rdata_valid}, 8'h00);
        check("rst.strobe", {7'h0, strobe_out}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        strobe_m = 1'b0;
        q0.delete(); q1.delete();
    endtask

    logic [7:0] rd;
    logic       v;
    logic [7:0] seq_exp [8];
    logic       tb [16];
    int         k;

    initial begin
        seq_exp = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.rdata", cpu_rdata, 8'h00);
        check("reset.valid", {7'h0, cpu_rdata_valid}, 8'h00);
        check("reset.strobe", {7'h0, strobe_out}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Exhausted after reset: reads return 1 before any strobe
        xfer("postreset.read", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
        check("postreset.const", rd, 8'h41);

        // Basic 8-bit serial read, then saturation
        pad_buttons = {8'h00, 8'b1000_0101};
        latch("seq");
        for (int i = 0; i < 8; i++) begin
            xfer("seq.read", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
            check("seq.const", rd, seq_exp[i]);
        end
        for (int i = 0; i < 2; i++) begin
            xfer("sat.read", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
            check("sat.const", rd, 8'h41);
        end

        // Strobe held: live A, no shift; release captures last strobe-cycle A
        pad_buttons = 16'h0000;
        xfer("live.s1", 16'h4016, 8'h01, 1'b1, 1'b0, rd);
        for (int i = 0; i < 3; i++) begin
            pad_buttons[0] = ~pad_buttons[0];
            xfer("live.read", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
            check("live.const", rd, {7'h20, pad_buttons[0]});
        end
        pad_buttons = 16'h00FF;
        xfer("live.s0", 16'h4016, 8'h00, 1'b1, 1'b0, rd);
        pad_buttons = 16'h0000;
        xfer("capture.read", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
        check("capture.const", rd, 8'h41);

        // Read and strobe write in the same cycle: read sees pre-write state
        pad_buttons = 16'h0002;
        latch("same");
        xfer("same.rdwr", 16'h4016, 8'h01, 1'b1, 1'b1, rd);
        check("same.const", rd, 8'h40);
        xfer("same.live", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
        xfer("same.s0", 16'h4016, 8'h00, 1'b1, 1'b0, rd);
        // Write to port 1 address is ignored
        xfer("wr4017", 16'h4017, 8'h01, 1'b1, 1'b0, rd);

        // Port independence
        pad_buttons = {8'h02, 8'hA5};
        latch("indep");
        xfer("indep.p1a", 16'h4017, 8'h00, 1'b0, 1'b1, rd);
        check("indep.p1a.const", rd, 8'h40);
        xfer("indep.p1b", 16'h4017, 8'h00, 1'b0, 1'b1, rd);
        check("indep.p1b.const", rd, 8'h41);
        xfer("indep.p0", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
        check("indep.p0.const", rd, 8'h41);

        // Reset mid-sequence abandons it; out-of-range read gives no pulse
        pad_buttons = 16'h0000;
        latch("midrst");
        for (int i = 0; i < 3; i++) xfer("midrst.read", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
        pulse_reset();
        xfer("midrst.after", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
        check("midrst.const", rd, 8'h41);
        step(16'h4018, 8'h00, 1'b0, 1'b1, rd, v);
        check("oob.valid", {7'h0, v}, 8'h00);

`ifndef JOYPAD_TURBO_EN
        // Turbo requests are ignored in the default build
        pad_buttons = 16'h0000;
        pad_turbo = 4'hF;
        latch("noturbo");
        xfer("noturbo.read", 16'h4016, 8'h00, 1'b0, 1'b1, rd);
        check("noturbo.const", rd, 8'h40);
        pad_turbo = 4'h0;
`else
        // Turbo A on port 0: live A follows a phase that flips every 4 cycles
        pad_buttons = 16'h0000;
        pad_turbo = 4'h1;
        step(16'h4016, 8'h01, 1'b1, 1'b0, rd, v);
        for (int i = 0; i < 16; i++) begin
            step(16'h4016, 8'h00, 1'b0, 1'b1, rd, v);
            tb[i] = rd[0];
        end
        k = -1;
        for (int i = 1; i < 5; i++) if (k < 0 && tb[i] != tb[i-1]) k = i;
        check("turbo.edge_found", {7'h0, k >= 0}, 8'h01);
        if (k >= 0) begin
            for (int j = k; j < 16; j++)
                check("turbo.phase", {7'h0, tb[j]}, {7'h0, tb[k] ^ 1'(((j - k) / 4) % 2)});
        end
        pad_turbo = 4'h0;
        step(16'h4016, 8'h00, 1'b1, 1'b0, rd, v);
        strobe_m = 1'b0;
        q0.delete(); q1.delete();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(pad_buttons[i]);
            q1.push_back(pad_buttons[8+i]);
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            int op;
            if ($urandom_range(0, 3) == 0) pad_buttons = 16'($urandom);
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1:    xfer("rnd.wr", 16'h4016, 8'($urandom), 1'b1, 1'b0, rd);
                2:       xfer("rnd.wr17", 16'h4017, 8'($urandom), 1'b1, 1'b0, rd);
                3:       xfer("rnd.rdwr", 16'h4016, 8'($urandom), 1'b1, 1'b1, rd);
                4:       xfer("rnd.oob", 16'h4018, 8'h00, 1'b0, 1'b1, rd);
                default: xfer("rnd.rd", 16'h4016 + 16'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b1, rd);
            endcase
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_joypad_port_ctrl
`default_nettype wire
